// File: rtl/pipe_pkg.sv
// Shared pipeline-register constants and per-boundary payload layouts.
// Stages pack/unpack their payload through these typedefs so both sides agree.
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam int          TW_DEF      = 2;
   localparam int          STALL_CNT_W = 8;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] pred_target;
   } fd_payload_t;

   typedef struct packed {
      logic [31:0] imm32;
      logic [31:0] rs_data;
   } de_payload_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] rt_data;
   } em_payload_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [31:0] mem_data;
   } mw_payload_t;

   localparam int PAYLOAD_W = $bits(de_payload_t);

endpackage

// File: rtl/pipe_stall_watchdog.sv
// Counts consecutive stall edges (saturating) and raises a sticky error at STALL_LIMIT.
// Cleared by flush or reset; a load zeroes the count but leaves the error set.
module pipe_stall_watchdog
   import pipe_pkg::*;
#(
   parameter int STALL_LIMIT = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   load,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   output logic                   stall_err
);

   localparam logic [STALL_CNT_W-1:0] LIMIT = STALL_CNT_W'(STALL_LIMIT);

   logic [STALL_CNT_W-1:0] cnt_inc;

   assign cnt_inc = (&stall_cnt) ? stall_cnt : stall_cnt + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         stall_err <= 1'b0;
      end else if (flush) begin
         stall_cnt <= '0;
         stall_err <= 1'b0;
      end else if (stall) begin
         stall_cnt <= cnt_inc;
         // error keys off the post-increment value so it lands on the LIMIT-th stall edge
         if (cnt_inc >= LIMIT) stall_err <= 1'b1;
      end else if (load) begin
         stall_cnt <= '0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register, 1-cycle latency; flush > stall (hold) > load each edge.
// Optional perf counters under `ifdef PIPE_STAGE_PERF_EN.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int          PW               = 64,
   parameter int          TW               = TW_DEF,
   parameter int          DEC_TNEW         = 1,
   parameter int          KEEP_PC_ON_FLUSH = 1,
   parameter logic [31:0] NOP_INSTR        = pipe_pkg::NOP_INSTR,
   parameter int          STALL_LIMIT      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   in_valid,
   input  logic [31:0]            in_pc,
   input  logic [31:0]            in_instr,
   input  logic [PW-1:0]          in_payload,
   input  logic [TW-1:0]          in_tnew,
   output logic                   out_valid,
   output logic [31:0]            out_pc,
   output logic [31:0]            out_instr,
   output logic [PW-1:0]          out_payload,
   output logic [TW-1:0]          out_tnew,
`ifdef PIPE_STAGE_PERF_EN
   output logic [31:0]            perf_valid_cnt,
   output logic [31:0]            perf_bubble_cnt,
   output logic [31:0]            perf_stall_tot,
`endif
   output logic [STALL_CNT_W-1:0] stall_cnt,
   output logic                   stall_err
);

   logic          load;
   logic [TW-1:0] tnew_nxt;
   logic [31:0]   flush_pc;

   assign load     = !flush && !stall;
   assign flush_pc = (KEEP_PC_ON_FLUSH != 0) ? in_pc : 32'h0;

   always_comb begin
      tnew_nxt = in_tnew;
      if (DEC_TNEW != 0 && in_tnew != '0) tnew_nxt = in_tnew - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid   <= 1'b0;
         out_pc      <= 32'h0;
         out_instr   <= NOP_INSTR;
         out_payload <= '0;
         out_tnew    <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         out_pc      <= flush_pc;
         out_instr   <= NOP_INSTR;
         out_payload <= '0;
         out_tnew    <= '0;
      end else if (load) begin
         out_valid   <= in_valid;
         out_pc      <= in_pc;
         out_instr   <= in_instr;
         out_payload <= in_payload;
         out_tnew    <= tnew_nxt;
      end
   end

   pipe_stall_watchdog #(
      .STALL_LIMIT (STALL_LIMIT)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .flush     (flush),
      .load      (load),
      .stall_cnt (stall_cnt),
      .stall_err (stall_err)
   );

`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_valid_cnt  <= 32'h0;
         perf_bubble_cnt <= 32'h0;
         perf_stall_tot  <= 32'h0;
      end else begin
         if (load && in_valid) perf_valid_cnt  <= perf_valid_cnt + 32'h1;
         if (flush)            perf_bubble_cnt <= perf_bubble_cnt + 32'h1;
         if (stall && !flush)  perf_stall_tot  <= perf_stall_tot + 32'h1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench: driver pushes hand-computed expectations, monitor compares on negedge.
// A second instance (no PC keep, no Tnew decrement) shares the inputs.
module tb_pipe_stage_reg;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic [63:0] in_payload;
   logic [1:0]  in_tnew;

   logic        out_valid,   a_valid;
   logic [31:0] out_pc,      a_pc;
   logic [31:0] out_instr,   a_instr;
   logic [63:0] out_payload, a_payload;
   logic [1:0]  out_tnew,    a_tnew;
   logic [7:0]  stall_cnt,   a_cnt;
   logic        stall_err,   a_err;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] perf_valid_cnt, perf_bubble_cnt, perf_stall_tot;
   logic [31:0] a_pv, a_pb, a_ps;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       nm;
      logic        v;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [63:0] pay;
      logic [1:0]  tn;
      logic [7:0]  cnt;
      logic        err;
      logic [31:0] apc;
      logic [1:0]  atn;
   } exp_t;

   exp_t sb[$];

   pipe_stage_reg #(
      .PW(64), .TW(2), .DEC_TNEW(1), .KEEP_PC_ON_FLUSH(1),
      .NOP_INSTR(32'h0000_0000), .STALL_LIMIT(4)
   ) u_dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
      .in_payload(in_payload), .in_tnew(in_tnew),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .out_payload(out_payload), .out_tnew(out_tnew),
`ifdef PIPE_STAGE_PERF_EN
      .perf_valid_cnt(perf_valid_cnt), .perf_bubble_cnt(perf_bubble_cnt),
      .perf_stall_tot(perf_stall_tot),
`endif
      .stall_cnt(stall_cnt), .stall_err(stall_err)
   );

   pipe_stage_reg #(
      .PW(64), .TW(2), .DEC_TNEW(0), .KEEP_PC_ON_FLUSH(0),
      .NOP_INSTR(32'h0000_0000), .STALL_LIMIT(4)
   ) u_alt (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
      .in_payload(in_payload), .in_tnew(in_tnew),
      .out_valid(a_valid), .out_pc(a_pc), .out_instr(a_instr),
      .out_payload(a_payload), .out_tnew(a_tnew),
`ifdef PIPE_STAGE_PERF_EN
      .perf_valid_cnt(a_pv), .perf_bubble_cnt(a_pb), .perf_stall_tot(a_ps),
`endif
      .stall_cnt(a_cnt), .stall_err(a_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(string nm, logic v, logic [31:0] pc, logic [31:0] ins,
                               logic [63:0] pay, logic [1:0] tn, logic [7:0] cnt,
                               logic err, logic [31:0] apc, logic [1:0] atn);
      exp_t e;
      e.nm = nm; e.v = v; e.pc = pc; e.ins = ins; e.pay = pay; e.tn = tn;
      e.cnt = cnt; e.err = err; e.apc = apc; e.atn = atn;
      return e;
   endfunction

   // Drive one edge's inputs, then queue what that edge must produce.
   task automatic step(input logic fl, input logic st, input logic v,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic [63:0] pay, input logic [1:0] tn, input exp_t e);
      @(negedge clk);
      flush = fl; stall = st; in_valid = v;
      in_pc = pc; in_instr = ins; in_payload = pay; in_tnew = tn;
      @(posedge clk);
      sb.push_back(e);
   endtask

   // Monitor
   initial begin
      exp_t e;
      logic [182:0] got, want;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            got  = {out_valid, out_pc, out_instr, out_payload, out_tnew,
                    stall_cnt, stall_err, a_pc, a_tnew};
            want = {e.v, e.pc, e.ins, e.pay, e.tn, e.cnt, e.err, e.apc, e.atn};
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL %s: got v=%b pc=%h ins=%h pay=%h tn=%0d cnt=%0d err=%b apc=%h atn=%0d ; want v=%b pc=%h ins=%h pay=%h tn=%0d cnt=%0d err=%b apc=%h atn=%0d",
                        e.nm, out_valid, out_pc, out_instr, out_payload, out_tnew,
                        stall_cnt, stall_err, a_pc, a_tnew,
                        e.v, e.pc, e.ins, e.pay, e.tn, e.cnt, e.err, e.apc, e.atn);
            end
         end
      end
   end

   localparam logic [31:0] P0 = 32'h3004;
   localparam logic [31:0] I0 = 32'h3c01_1234;

   initial begin
      reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_pc = '0; in_instr = '0; in_payload = '0; in_tnew = '0;
      #1 sb.push_back(mk("reset_init", 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      #1 reset = 1'b1;

      step(0, 0, 1, 32'h3000, 32'h0000_1111, 64'hAA, 2'd3,
           mk("load_tnew3", 1, 32'h3000, 32'h0000_1111, 64'hAA, 2'd2, 0, 0, 32'h3000, 2'd3));

      // asynchronous reset mid-cycle with a loaded register
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #3 reset = 1'b0;
      sb.push_back(mk("reset_async", 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      #1 reset = 1'b1;

      step(0, 0, 0, 32'h2ffc, 32'h0123_4567, 64'h55, 2'd0,
           mk("load_tnew0_inv", 0, 32'h2ffc, 32'h0123_4567, 64'h55, 2'd0, 0, 0, 32'h2ffc, 2'd0));
      step(0, 0, 1, P0, I0, 64'h1111, 2'd2,
           mk("load_tnew2", 1, P0, I0, 64'h1111, 2'd1, 0, 0, P0, 2'd2));
      step(0, 1, 1, 32'h4000, 32'hffff_ffff, 64'h9, 2'd3,
           mk("stall1", 1, P0, I0, 64'h1111, 2'd1, 8'd1, 0, P0, 2'd2));
      step(0, 1, 0, 32'h4004, 32'hffff_fffe, 64'h8, 2'd3,
           mk("stall2", 1, P0, I0, 64'h1111, 2'd1, 8'd2, 0, P0, 2'd2));
      step(0, 1, 1, 32'h4008, 32'hffff_fffd, 64'h7, 2'd0,
           mk("stall3", 1, P0, I0, 64'h1111, 2'd1, 8'd3, 0, P0, 2'd2));
      step(0, 1, 1, 32'h400c, 32'hffff_fffc, 64'h6, 2'd1,
           mk("stall4_err", 1, P0, I0, 64'h1111, 2'd1, 8'd4, 1, P0, 2'd2));
      step(0, 0, 1, 32'h300c, 32'h2222_0000, 64'h33, 2'd1,
           mk("load_err_sticky", 1, 32'h300c, 32'h2222_0000, 64'h33, 2'd0, 0, 1, 32'h300c, 2'd1));
      step(1, 1, 1, 32'h3008, 32'hffff_ffff, 64'hFF, 2'd3,
           mk("flush_over_stall", 0, 32'h3008, 0, 0, 0, 0, 0, 0, 0));
      step(0, 1, 1, 32'h6000, 32'h1234_5678, 64'h44, 2'd2,
           mk("stall_bubble", 0, 32'h3008, 0, 0, 0, 8'd1, 0, 0, 0));
      step(1, 0, 1, 32'h5000, 32'h1111_1111, 64'h22, 2'd2,
           mk("flush_alone", 0, 32'h5000, 0, 0, 0, 0, 0, 0, 0));
      step(0, 0, 1, 32'h5004, 32'h8c22_0004, 64'hdead_beef, 2'd0,
           mk("load_after_flush", 1, 32'h5004, 32'h8c22_0004, 64'hdead_beef, 0, 0, 0, 32'h5004, 0));
      step(0, 0, 0, 32'h0, 32'h0, 64'h0, 2'd0,
           mk("load_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0));

      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end

`ifdef PIPE_STAGE_PERF_EN
      checks++;
      if (perf_valid_cnt !== 32'd3) begin
         errors++;
         $display("FAIL perf_valid_cnt: got %0d want 3", perf_valid_cnt);
      end
      checks++;
      if (perf_bubble_cnt !== 32'd2) begin
         errors++;
         $display("FAIL perf_bubble_cnt: got %0d want 2", perf_bubble_cnt);
      end
      checks++;
      if (perf_stall_tot !== 32'd5) begin
         errors++;
         $display("FAIL perf_stall_tot: got %0d want 5", perf_stall_tot);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
